adder_share_arb: RTL and testbench
==================================

Name: adder_share_arb

Overview:
- Shares a single 3-operand adder (a+b+c) among num_req_p requesters.
- Each requester presents operands with a valid/ready handshake. A round-robin arbiter grants one requester per cycle.
- The registered result is returned on one output channel, tagged with the requester id.
- Sits between the operand producers and the shared adder datapath, replacing per-client adder instances.

Parameters:
- width_p, 4, operand width in bits
- num_req_p, 4, number of requesters (>=2)
- id_width_lp, $clog2(num_req_p), derived localparam, width of the id tag

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  asynchronous, active-high reset
- req_v_i  in  num_req_p  per-requester operand valid
- req_a_i  in  num_req_p*width_p  packed operand a; requester k in bits [k*width_p +: width_p]
- req_b_i  in  num_req_p*width_p  packed operand b, same packing
- req_c_i  in  num_req_p*width_p  packed operand c, same packing
- req_ready_o  out  num_req_p  one-hot-or-zero grant/accept per requester
- v_o  out  1  result valid
- sum_o  out  width_p+2  registered a+b+c of the granted requester
- id_o  out  id_width_lp  index of the requester that produced sum_o
- ready_i  in  1  consumer accepts result

Behaviour:
- Reset (async assert): v_o=0, sum_o=0, id_o=0, req_ready_o=0, round-robin pointer=0 (requester 0 highest priority). Deassertion is sampled synchronously at the next edge.
- Output slot is a single register with two states:
  - EMPTY: v_o=0.
  - FULL: v_o=1.
- can_accept = (state==EMPTY) | (ready_i & v_o). A full slot drained this cycle accepts a new operand in the same cycle (full throughput, 1 result/cycle).
- Grant when can_accept=1 and any req_v_i bit is set:
  - Scan from pointer upward with wraparound; the first valid requester k wins.
  - req_ready_o[k]=1; all other bits are 0. Combinational from req_v_i, pointer and state.
- When can_accept=0, req_ready_o=0.
- Transfer on requester k occurs when req_v_i[k] & req_ready_o[k]. At the next edge:
  - sum_o <= zero-extended a_k+b_k+c_k, computed at width_p+2 (exact; max 3*(2^width_p-1) fits, no truncation)
  - id_o <= k
  - state <= FULL
  - pointer <= (k+1) mod num_req_p
- Latency: operand accepted in cycle N; result visible with v_o=1 in cycle N+1.
- No transfer while can_accept=1: state <= EMPTY if the slot drained, otherwise it stays. sum_o and id_o hold their last values.
- FULL & ready_i=0: sum_o, id_o and v_o are stable; no grant is issued.
- Pointer advances only on a transfer. Idle cycles and consumer stalls leave it unchanged.
- A requester must hold req_v_i and its operands stable until accepted. The arbiter does not latch unaccepted operands.
- Single requester active: it is granted every cycle the slot can accept.
- Pointer wraps from num_req_p-1 to 0.
- Reset mid-operation: a pending result is discarded, v_o drops immediately (async), and the pointer returns to 0.

Optional Feature:
- Macro: ADDER_SHARE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index valid requester always wins; the pointer register is removed. All handshake, latency and reset rules are unchanged.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset, all req_v_i=0 -> v_o=0, sum_o=0, id_o=0, req_ready_o=0 across 5 cycles. Asserting reset_i mid-cycle with v_o=1 drops v_o before the next edge.
- Requester 2 only, a=15 b=15 c=15, ready_i=1 -> req_ready_o=4'b0100; next cycle v_o=1, sum_o=45, id_o=2.
- All four requesters valid continuously, ready_i=1 -> grants in order 0,1,2,3,0, one per cycle. id_o lags the grant by one cycle.
- Requester 1 valid, ready_i=0 with slot FULL -> req_ready_o=0 and sum_o/id_o held for 3 cycles. Raising ready_i -> drain and grant in the same cycle, and the new result appears on the next cycle.
- Requesters 0 and 3 valid with pointer=1 -> 3 is granted first, then 0. With ADDER_SHARE_ARB_FIXED_PRIO_EN defined, 0 is granted repeatedly while it stays valid.
- Random operands, 1000 cycles -> every accepted (a,b,c,k) yields exactly one result with sum_o=a+b+c and id_o=k. No result is lost or duplicated under random ready_i.

Source files
------------

// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - one registered a+b+c adder shared by num_req_p requesters via round-robin grant.
// Define ADDER_SHARE_ARB_FIXED_PRIO_EN for fixed lowest-index priority (no pointer register).
module adder_share_arb #(
    parameter int width_p   = 4,
    parameter int num_req_p = 4,
    localparam int id_width_lp = $clog2(num_req_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_req_p-1:0]           req_v_i,
    input  logic [num_req_p*width_p-1:0]   req_a_i,
    input  logic [num_req_p*width_p-1:0]   req_b_i,
    input  logic [num_req_p*width_p-1:0]   req_c_i,
    output logic [num_req_p-1:0]           req_ready_o,
    output logic                           v_o,
    output logic [width_p+1:0]             sum_o,
    output logic [id_width_lp-1:0]         id_o,
    input  logic                           ready_i
);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e                   state_q;
    logic [width_p+1:0]       sum_q;
    logic [id_width_lp-1:0]   id_q;

    logic                     can_accept;
    logic                     found;
    logic                     grant_v;
    logic [id_width_lp-1:0]   gnt_id;
    logic [num_req_p-1:0]     gnt_vec;
    logic [width_p+1:0]       sum_d;

`ifndef ADDER_SHARE_ARB_FIXED_PRIO_EN
    logic [id_width_lp-1:0]   ptr_q;
    logic [id_width_lp-1:0]   ptr_d;
`endif

    assign v_o        = (state_q == FULL);
    assign sum_o      = sum_q;
    assign id_o       = id_q;
    assign can_accept = (state_q == EMPTY) | (ready_i & v_o);

    // Scan requesters starting at the priority pointer, wrapping past the last index.
    always_comb begin
        found   = 1'b0;
        gnt_id  = '0;
        gnt_vec = '0;
        for (int i = 0; i < num_req_p; i++) begin
            int idx;
`ifdef ADDER_SHARE_ARB_FIXED_PRIO_EN
            idx = i;
`else
            idx = int'(ptr_q) + i;
            if (idx >= num_req_p) begin
                idx = idx - num_req_p;
            end
`endif
            if (!found && req_v_i[idx]) begin
                found        = 1'b1;
                gnt_id       = id_width_lp'(idx);
                gnt_vec[idx] = can_accept;
            end
        end
        grant_v = found & can_accept;
    end

    assign req_ready_o = gnt_vec;

    assign sum_d = (width_p+2)'(req_a_i[int'(gnt_id)*width_p +: width_p])
                 + (width_p+2)'(req_b_i[int'(gnt_id)*width_p +: width_p])
                 + (width_p+2)'(req_c_i[int'(gnt_id)*width_p +: width_p]);

`ifndef ADDER_SHARE_ARB_FIXED_PRIO_EN
    assign ptr_d = (gnt_id == id_width_lp'(num_req_p - 1)) ? '0 : gnt_id + 1'b1;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= EMPTY;
            sum_q   <= '0;
            id_q    <= '0;
`ifndef ADDER_SHARE_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else if (grant_v) begin
            sum_q   <= sum_d;
            id_q    <= gnt_id;
            state_q <= FULL;
`ifndef ADDER_SHARE_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end else if (can_accept) begin
            // Either already empty or drained this cycle with nothing to replace it.
            state_q <= EMPTY;
        end
    end

endmodule

// File: tb/tb_adder_share_arb.sv
// tb/tb_adder_share_arb.sv - randomized self-checking bench for adder_share_arb with a queue-based reference model.
module tb_adder_share_arb;
    localparam int W = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_i;
    logic [N-1:0]   req_v_i;
    logic [N*W-1:0] req_a_i, req_b_i, req_c_i;
    logic [N-1:0]   req_ready_o;
    logic           v_o;
    logic [W+1:0]   sum_o;
    logic [1:0]     id_o;
    logic           ready_i;

    adder_share_arb #(.width_p(W), .num_req_p(N)) dut (
        .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i),
        .req_ready_o(req_ready_o), .v_o(v_o), .sum_o(sum_o), .id_o(id_o),
        .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    bit m_full;
    int m_sum, m_id, m_ptr;
    int q_sum[$];
    int q_id[$];

    function automatic int opsum(int k);
        return int'(req_a_i[k*W +: W]) + int'(req_b_i[k*W +: W]) + int'(req_c_i[k*W +: W]);
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g = '0;
        if (m_full && !ready_i) return g;
        for (int i = 0; i < N; i++) begin
            int k;
`ifdef ADDER_SHARE_ARB_FIXED_PRIO_EN
            k = i;
`else
            k = (m_ptr + i) % N;
`endif
            if (req_v_i[k]) begin
                g[k] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic set_req(int k, int a, int b, int c);
        req_a_i[k*W +: W] = W'(a);
        req_b_i[k*W +: W] = W'(b);
        req_c_i[k*W +: W] = W'(c);
    endtask

    task automatic model_reset();
        m_full = 0; m_sum = 0; m_id = 0; m_ptr = 0;
    endtask

    // Advance one clock and update the reference model from the inputs held this cycle.
    task automatic tick();
        logic [N-1:0] g;
        int k;
        int s;
        g = exp_grant();
        k = -1;
        for (int i = 0; i < N; i++) if (g[i]) k = i;
        s = (k >= 0) ? opsum(k) : 0;
        @(posedge clk); #1;
        if (k >= 0) begin
            m_full = 1; m_sum = s; m_id = k; m_ptr = (k + 1) % N;
        end else if (m_full && ready_i) begin
            m_full = 0;
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1; req_v_i = '0; ready_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset_i = 1'b1; req_v_i = '0; ready_i = 1'b1;
        req_a_i = '0; req_b_i = '0; req_c_i = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp += 4;
            if (v_o !== 1'b0) begin n_err++; $display("FAIL reset_v: got %0b want 0", v_o); end
            if (sum_o !== '0) begin n_err++; $display("FAIL reset_sum: got %0d want 0", sum_o); end
            if (id_o !== '0) begin n_err++; $display("FAIL reset_id: got %0d want 0", id_o); end
            if (req_ready_o !== '0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready_o); end
        end
        @(posedge clk); #1;
        reset_i = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        set_req(2, 15, 15, 15);
        req_v_i = 4'b0100; ready_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready_o !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b want 0100", req_ready_o); end
        tick();
        req_v_i = '0;
        @(negedge clk);
        n_cmp += 3;
        if (v_o !== 1'b1) begin n_err++; $display("FAIL single_v: got %0b want 1", v_o); end
        if (sum_o !== 6'd45) begin n_err++; $display("FAIL single_sum: got %0d want 45", sum_o); end
        if (id_o !== 2'd2) begin n_err++; $display("FAIL single_id: got %0d want 2", id_o); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] e;
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, $urandom_range(15), $urandom_range(15), $urandom_range(15));
        req_v_i = 4'b1111; ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e = '0;
            e[i % N] = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (req_ready_o !== e) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready_o, e); end
            if (i > 0) begin
                n_cmp += 2;
                if (id_o !== 2'((i - 1) % N)) begin n_err++; $display("FAIL rr_id%0d: got %0d want %0d", i, id_o, (i - 1) % N); end
                if (int'(sum_o) !== opsum((i - 1) % N)) begin n_err++; $display("FAIL rr_sum%0d: got %0d want %0d", i, sum_o, opsum((i - 1) % N)); end
            end
            tick();
        end
        req_v_i = '0;
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        set_req(1, 3, 4, 5);
        req_v_i = 4'b0010; ready_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready_o !== 4'b0010) begin n_err++; $display("FAIL stall_first_grant: got %b want 0010", req_ready_o); end
        tick();
        set_req(1, 7, 7, 7);
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp += 4;
            if (req_ready_o !== '0) begin n_err++; $display("FAIL stall_ready%0d: got %b want 0000", i, req_ready_o); end
            if (v_o !== 1'b1) begin n_err++; $display("FAIL stall_v%0d: got %0b want 1", i, v_o); end
            if (sum_o !== 6'd12) begin n_err++; $display("FAIL stall_sum%0d: got %0d want 12", i, sum_o); end
            if (id_o !== 2'd1) begin n_err++; $display("FAIL stall_id%0d: got %0d want 1", i, id_o); end
            tick();
        end
        ready_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready_o !== 4'b0010) begin n_err++; $display("FAIL stall_drain_grant: got %b want 0010", req_ready_o); end
        tick();
        req_v_i = '0;
        @(negedge clk);
        n_cmp += 2;
        if (v_o !== 1'b1) begin n_err++; $display("FAIL stall_new_v: got %0b want 1", v_o); end
        if (sum_o !== 6'd21) begin n_err++; $display("FAIL stall_new_sum: got %0d want 21", sum_o); end
        tick();
    endtask

    task automatic test_priority_order();
        logic [N-1:0] e1, e2;
`ifdef ADDER_SHARE_ARB_FIXED_PRIO_EN
        e1 = 4'b0001; e2 = 4'b0001;
`else
        e1 = 4'b1000; e2 = 4'b0001;
`endif
        do_reset();
        set_req(0, 1, 2, 3);
        set_req(3, 9, 9, 9);
        req_v_i = 4'b0001; ready_i = 1'b1;
        @(negedge clk);
        tick();
        req_v_i = 4'b1001;
        @(negedge clk);
        n_cmp++;
        if (req_ready_o !== e1) begin n_err++; $display("FAIL order_first: got %b want %b", req_ready_o, e1); end
        tick();
        @(negedge clk);
        n_cmp++;
        if (req_ready_o !== e2) begin n_err++; $display("FAIL order_second: got %b want %b", req_ready_o, e2); end
        tick();
        req_v_i = '0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        set_req(0, 5, 5, 5);
        set_req(1, 1, 1, 1);
        req_v_i = 4'b0001; ready_i = 1'b1;
        @(negedge clk);
        tick();
        req_v_i = '0;
        @(negedge clk);
        n_cmp++;
        if (v_o !== 1'b1) begin n_err++; $display("FAIL areset_pre_v: got %0b want 1", v_o); end
        #2 reset_i = 1'b1;
        #1;
        n_cmp += 2;
        if (v_o !== 1'b0) begin n_err++; $display("FAIL areset_v: got %0b want 0", v_o); end
        if (sum_o !== '0) begin n_err++; $display("FAIL areset_sum: got %0d want 0", sum_o); end
        @(posedge clk); #1;
        reset_i = 1'b0;
        model_reset();
        req_v_i = 4'b0011;
        @(negedge clk);
        n_cmp++;
        if (req_ready_o !== 4'b0001) begin n_err++; $display("FAIL areset_ptr: got %b want 0001", req_ready_o); end
        tick();
        req_v_i = '0;
        tick();
    endtask

    task automatic check_pop(string tag);
        if (v_o && ready_i) begin
            n_cmp++;
            if (q_sum.size() == 0) begin
                n_err++; $display("FAIL %s_dup: got result sum %0d id %0d want none", tag, sum_o, id_o);
            end else begin
                int es, ei;
                es = q_sum.pop_front();
                ei = q_id.pop_front();
                n_cmp++;
                if (int'(sum_o) !== es || int'(id_o) !== ei) begin
                    n_err++; $display("FAIL %s_result: got sum %0d id %0d want sum %0d id %0d", tag, sum_o, id_o, es, ei);
                end
            end
        end
    endtask

    task automatic test_random();
        bit pend[N];
        logic [N-1:0] e, acc;
        do_reset();
        q_sum.delete(); q_id.delete();
        for (int k = 0; k < N; k++) pend[k] = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(1) == 1) begin
                    set_req(k, $urandom_range(15), $urandom_range(15), $urandom_range(15));
                    pend[k] = 1;
                end
                req_v_i[k] = pend[k];
            end
            ready_i = ($urandom_range(3) != 0);
            @(negedge clk);
            e = exp_grant();
            n_cmp += 2;
            if (req_ready_o !== e) begin n_err++; $display("FAIL rand_grant c%0d: got %b want %b", cyc, req_ready_o, e); end
            if (v_o !== m_full) begin n_err++; $display("FAIL rand_v c%0d: got %0b want %0b", cyc, v_o, m_full); end
            check_pop("rand");
            acc = req_v_i & req_ready_o;
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    q_sum.push_back(opsum(k));
                    q_id.push_back(k);
                end
            end
            tick();
            for (int k = 0; k < N; k++) if (acc[k]) pend[k] = 0;
        end
        req_v_i = '0; ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_pop("drain");
            tick();
        end
        n_cmp++;
        if (q_sum.size() != 0) begin n_err++; $display("FAIL rand_lost: got %0d outstanding want 0", q_sum.size()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_priority_order();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
